// File: rtl/dmem_responder.sv
// Word-organised data-memory responder for the single-cycle MIPS datapath.
// Adds programmable wait states, a busy/done handshake and rejection of illegal accesses.
module dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        addr_err
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic               op_w_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        wdata_r;
    logic               err_r;
    logic               busy_r;
    logic               done_r;
    logic               addr_err_r;
    logic [31:0]        rdata_r;
    logic [31:0]        mem_r [DEPTH_WORDS];

    logic               req_s;
    logic [29:0]        word_s;
    logic               legal_s;
    logic [IDX_W-1:0]   index_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_idx_s;
    logic [31:0]        mem_wd_s;

    // Legality check on the live request; the word offset only matters once alignment holds.
    always_comb begin
        req_s   = dm_r | dm_w;
        word_s  = addr[31:2] - ADDR_BASE[31:2];
        legal_s = (addr[1:0] == 2'b00) && (addr >= ADDR_BASE) &&
                  ({2'b00, word_s} < DEPTH_L) && !(dm_r && dm_w);
        index_s = word_s[IDX_W-1:0];
    end

    // RAM write strobe: fires only on the edge that enters RESP for a legal write.
    always_comb begin
        mem_we_s  = 1'b0;
        mem_idx_s = idx_r;
        mem_wd_s  = wdata_r;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_IDLE && req_s && legal_s && dm_w && WAIT_L == 4'd0) begin
            mem_we_s  = 1'b1;
            mem_idx_s = index_s;
            mem_wd_s  = wdata;
        end else if (state_r == ST_WAIT && cnt_r <= 4'd1 && op_w_r && !err_r) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Backing RAM, deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_idx_s] <= mem_wd_s;
        end
    end

    // Handshake FSM with registered outputs and the read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            op_w_r     <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= 32'd0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            addr_err_r <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r     <= 1'b0;
                    addr_err_r <= 1'b0;
                    if (req_s) begin
                        op_w_r  <= dm_w;
                        idx_r   <= index_s;
                        wdata_r <= wdata;
                        cnt_r   <= WAIT_L;
                        err_r   <= !legal_s;
                        if (!legal_s) begin
                            state_r    <= ST_RESP;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            addr_err_r <= 1'b1;
                        end else if (WAIT_L == 4'd0) begin
                            state_r <= ST_RESP;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            if (!dm_w) begin
                                rdata_r <= mem_r[index_s];
                            end
                        end else begin
                            state_r <= ST_WAIT;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    // A zero count can only come from corruption; finish rather than wrap.
                    if (cnt_r <= 4'd1) begin
                        state_r    <= ST_RESP;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        addr_err_r <= err_r;
                        if (!op_w_r && !err_r) begin
                            rdata_r <= mem_r[idx_r];
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    addr_err_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 4'd0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    addr_err_r <= 1'b0;
                end
            endcase
        end
    end

    assign rdata    = rdata_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign addr_err = addr_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        r2, w2, r0, w0;
    logic [31:0] a2, wd2, a0, wd0;
    logic [31:0] rd2_s, rd0_s;
    logic        busy2_s, done2_s, err2_s, busy0_s, done0_s, err0_s;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .dm_r(r2), .dm_w(w2), .addr(a2), .wdata(wd2),
        .rdata(rd2_s), .busy(busy2_s), .done(done2_s), .addr_err(err2_s));

    dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .dm_r(r0), .dm_w(w0), .addr(a0), .wdata(wd0),
        .rdata(rd0_s), .busy(busy0_s), .done(done0_s), .addr_err(err0_s));

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
        logic [7:0]  lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem2_m[int];
    logic [31:0] mem0_m[int];
    logic [31:0] rdm2, rdm0;
    int          total = 0;
    int          bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input logic [31:0] a, input logic r, input logic w);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] == 2'b00) && (a >= BASE) && ((off >> 2) < DEPTH) && !(r && w);
    endfunction

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin r0 = r; w0 = w; a0 = a; wd0 = wd; end
        else     begin r2 = r; w2 = w; a2 = a; wd2 = wd; end
    endtask

    // Model one request and push the expected completion.
    task automatic push_exp(input bit sel, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   idx;
        logic lg;
        lg  = is_legal(a, r, w);
        idx = int'((a - BASE) >> 2);
        e.err = !lg;
        e.lat = lg ? (sel ? 8'd1 : 8'd3) : 8'd1;
        if (lg && w) begin
            if (sel) mem0_m[idx] = wd; else mem2_m[idx] = wd;
        end
        if (lg && r) begin
            if (sel) rdm0 = mem0_m[idx]; else rdm2 = mem2_m[idx];
        end
        e.rd = sel ? rdm0 : rdm2;
        exp_q.push_back(e);
    endtask

    // One complete transaction, entered and left on a negedge with the DUT idle.
    task automatic access(input string tag, input bit sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   nb;
        int   lat;
        bit   got;
        nb = 0; lat = 0; got = 0;
        push_exp(sel, r, w, a, wd);
        drive(sel, r, w, a, wd);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (sel ? busy0_s : busy2_s) nb++;
            if (sel ? done0_s : done2_s) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        e = exp_q.pop_front();
        if (!got) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, "_err"}, {31'd0, sel ? err0_s : err2_s}, {31'd0, e.err});
            check_eq({tag, "_rdata"}, sel ? rd0_s : rd2_s, e.rd);
            check_eq({tag, "_lat"}, 32'(lat), {24'd0, e.lat});
            check_eq({tag, "_busy"}, 32'(nb), e.err ? 32'd0 : 32'(int'(e.lat) - 1));
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int   last_done;
        int   k;
        int   bz;
        exp_t e;
        rst = 1'b1;
        rdm2 = 32'd0; rdm0 = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {rd2_s[0], busy2_s, done2_s, err2_s}, 32'd0);
        check_eq("rst_rdata", rd2_s | rd0_s, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access("wr8",      1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
        access("rd8",      1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'd0);
        access("wr12",     1'b0, 1'b0, 1'b1, 32'h1001_000C, 32'hAAAA_0003);
        access("misalign", 1'b0, 1'b1, 1'b0, 32'h1001_0006, 32'd0);
        access("past_end", 1'b0, 1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'h5555_5555);
        access("below",    1'b0, 1'b1, 1'b0, 32'h1000_FFFC, 32'd0);
        access("wr_last",  1'b0, 1'b0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'h0F0F_5A5A);
        access("rd_last",  1'b0, 1'b1, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'd0);
        access("both",     1'b0, 1'b1, 1'b1, 32'h1001_0008, 32'h1111_1111);
        access("rd_after", 1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'd0);

        // Reset during WAIT must drop the pending write and clear outputs.
        drive(1'b0, 1'b0, 1'b1, 32'h1001_000C, 32'h1234_5678);
        @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy2_s}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_outs", {29'd0, busy2_s, done2_s, err2_s}, 32'd0);
        check_eq("mid_rst_rdata", rd2_s, 32'd0);
        rdm2 = 32'd0; rdm0 = 32'd0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        access("rd12_old", 1'b0, 1'b1, 1'b0, 32'h1001_000C, 32'd0);

        // Zero-wait instance: preload, then held back-to-back reads.
        for (int i = 0; i < 4; i++)
            access("z_wr", 1'b1, 1'b0, 1'b1, BASE + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 7));
        last_done = -1; k = 0; bz = 0;
        push_exp(1'b1, 1'b1, 1'b0, BASE, 32'd0);
        drive(1'b1, 1'b1, 1'b0, BASE, 32'd0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (busy0_s) bz++;
            if (done0_s) begin
                e = exp_q.pop_front();
                check_eq("b2b_rdata", rd0_s, e.rd);
                check_eq("b2b_err", {31'd0, err0_s}, {31'd0, e.err});
                if (last_done >= 0) check_eq("b2b_gap", 32'(cyc - last_done), 32'd2);
                last_done = cyc;
                k++;
                if (k == 4) break;
                push_exp(1'b1, 1'b1, 1'b0, BASE + 32'(4 * k), 32'd0);
                drive(1'b1, 1'b1, 1'b0, BASE + 32'(4 * k), 32'd0);
            end
        end
        check_eq("b2b_count", 32'(k), 32'd4);
        check_eq("b2b_busy", 32'(bz), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS datapath. Services the read (dm_r) and write (dm_w) strobes issued by the CPU control unit.
- Backing RAM is word-organised and sits behind a fixed address window.
- Adds programmable wait states and a registered handshake (busy/done), so the CPU can stall on slow memory.
- Reports misaligned, out-of-window and conflicting accesses via addr_err, without touching memory.

Parameters:
- ADDR_BASE, 32'h1001_0000, byte address of word 0 of the RAM window.
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two, >=2).
- WAIT_CYCLES, 2, busy cycles between accept and response (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- dm_r  input  1  read request; held by CPU until done.
- dm_w  input  1  write request; held by CPU until done.
- addr  input  32  byte address of the access.
- wdata  input  32  write data; sampled at accept.
- rdata  output  32  read data; valid when done=1 for a read; holds its value until the next successful read.
- busy  output  1  request accepted and in progress; CPU stalls while high.
- done  output  1  one-cycle completion pulse.
- addr_err  output  1  asserted together with done when the access was rejected.

Behaviour:
- Reset: all outputs 0 (rdata=0, busy=0, done=0, addr_err=0); FSM to IDLE; wait counter 0. RAM contents are not cleared.
- Registers: state (IDLE, WAIT, RESP), wait counter of 4 bits, latched addr/wdata/op, error flag.
- Legality check, evaluated at accept:
  - addr[1:0]==0;
  - addr>=ADDR_BASE;
  - (addr-ADDR_BASE)>>2 < DEPTH_WORDS;
  - not (dm_r && dm_w).
  - Word index = (addr-ADDR_BASE)>>2, truncated to clog2(DEPTH_WORDS) bits after the range check.
- IDLE:
  - If dm_r||dm_w, the request is accepted at this edge: latch op/index/wdata, load counter=WAIT_CYCLES.
  - Illegal request: go to RESP with the error flag set.
  - Legal request with WAIT_CYCLES==0: go to RESP.
  - Otherwise go to WAIT.
  - No request: stay in IDLE.
- WAIT:
  - busy=1; counter decrements each cycle.
  - On the cycle counter==1, transition to RESP.
  - Exactly WAIT_CYCLES busy cycles occur.
- On the WAIT->RESP (or IDLE->RESP) edge for a legal access:
  - write: RAM[index]<=latched wdata;
  - read: rdata<=RAM[index] (read-before-write not applicable; single op).
- RESP:
  - done=1, busy=0, addr_err=error flag; lasts one cycle, then unconditionally back to IDLE.
  - Requests present during RESP are ignored, because the CPU is still holding the completing request.
  - A fresh request is accepted only in IDLE, giving at least one idle cycle between transactions.
- Latency: accept at edge N → done high during cycle N+1+WAIT_CYCLES.
- Error path: no wait states; done+addr_err one cycle after accept; RAM and rdata unchanged.
- Input changes after accept are ignored; the latched values are used.
- Reset mid-operation (WAIT or RESP): return to IDLE; a pending write is dropped (RAM not written); outputs cleared.
- busy, done and addr_err are registered outputs (no combinational path from inputs).

Test Plan:
- Reset, WAIT_CYCLES=2:
  - dm_w=1, addr=32'h1001_0008, wdata=32'hDEAD_BEEF → busy=1 for 2 cycles, then done=1, addr_err=0.
  - Then dm_r at the same address → rdata=32'hDEADBEEF with done.
- Misaligned read at addr=32'h1001_0006 → done=1 and addr_err=1 one cycle after accept, busy never high, rdata unchanged.
- Out-of-window access:
  - addr=ADDR_BASE+4*DEPTH_WORDS → addr_err=1.
  - addr=32'h1000_FFFC → addr_err=1.
  - Last word (ADDR_BASE+4*(DEPTH_WORDS-1)) → accepted, written and read back.
- dm_r=dm_w=1 together → addr_err=1; a subsequent read of that address returns the prior contents.
- Start write of 32'h1234_5678 to word 3, assert rst during WAIT → all outputs 0 next cycle; read of word 3 returns old value.
- WAIT_CYCLES=0 build: back-to-back read requests held until done → done every second cycle, busy never asserted, rdata correct each time.
